nmea_sentence_capture: RTL and testbench
========================================

Name: nmea_sentence_capture

Overview:
- Parametrised successor to the single-buffer GPS byte logger.
- Hunts a UART byte stream for one NMEA sentence type, matched by a configurable tag, and verifies its XOR checksum.
- Commits only good sentences into a double-buffered byte store.
- The VGA/debug side reads the last good sentence as little-endian words by word address, with no tearing mid-update.

Parameters:
- DEPTH, 64, byte capacity of each bank for tag plus body; power of 2, ≥ 8.
- WORD_BYTES, 4, bytes per read word; power of 2, divides DEPTH.
- TAG, "GPRMC", 40-bit 5-char sentence tag; first char in bits 39:32.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- data  in  8  received UART byte.
- data_valid  in  1  one-cycle strobe, synchronous to clk, qualifying data.
- rd_addr  in  log2(DEPTH/WORD_BYTES)  word address into the display bank.
- rd_data  out  8*WORD_BYTES  word read; byte k = buffer[rd_addr*WORD_BYTES+k] in bits 8k+7:8k.
- frame_len  out  log2(DEPTH)+1  byte count of the displayed sentence.
- frame_valid  out  1  sticky; high after the first good sentence.
- frame_stb  out  1  one-cycle pulse on commit of a good sentence.
- err_stb  out  1  one-cycle pulse on a rejected sentence.
- err_code  out  2  01 checksum mismatch, 10 overflow, 11 malformed; holds until the next err_stb.

Behaviour:
- Clock and reset: single clock clk; reset asynchronous, active-high.
- Reset values: state IDLE; write pointer 0; display bank 0; rd_data 0; frame_len 0; frame_valid, frame_stb, err_stb 0; err_code 00.
- Bank RAM contents are not cleared by reset.
- FSM advances only on cycles with data_valid=1; other cycles hold state.
- Stored bytes are those strictly between '$' and '*', tag included. Checksum = XOR of the same bytes.

FSM states and transitions:
- IDLE: on '$' (8'h24), clear XOR and pointer, go to TAG. All other bytes are ignored.
- TAG: compare the byte to TAG char [idx].
  - Match: store it, XOR it, idx++; after 5 matches go to BODY.
  - Mismatch: go to IDLE silently, no error.
- BODY:
  - '*' (8'h2A): go to CK_HI.
  - CR or LF: err 11, go to IDLE.
  - Any other byte when pointer == DEPTH: err 10, go to IDLE.
  - Otherwise store it and XOR it.
- CK_HI / CK_LO: accept hex digits 0-9, A-F, a-f; any other byte gives err 11 and IDLE.
- After CK_LO, compare {hi,lo} to the XOR.
  - Equal: commit.
  - Unequal: err 01.
  - Either way, go to IDLE.
- '$' in TAG, BODY, CK_HI or CK_LO: restart at TAG, discard the partial sentence, raise no error.

Commit and error timing:
- Commit happens at the clk edge sampling the second checksum byte. On that edge:
  - display bank toggles;
  - frame_len ← pointer;
  - frame_valid ← 1;
  - frame_stb is high for the following cycle.
- err_stb and err_code update on the same edge as the rejecting byte.
- Writes always target the non-display bank, so a failed sentence never disturbs the displayed data.

Read path:
- Registered read, latency 1 cycle: rd_data at edge n+1 reflects rd_addr at edge n.
- A byte at index ≥ frame_len reads as 8'h20 (space padding for the display).
- A read on the commit edge returns the old bank. The next edge returns the new bank.

Reset mid-sentence:
- The partial sentence is discarded.
- frame_len=0, so every read returns 8'h20 from the first edge after reset release.

Decomposition:
- Package nmea_pkg:
  - ASCII constants '$', '*', CR, LF, space;
  - state enum;
  - err_code constants;
  - function hex_to_nibble returning a valid flag.
- Sub-module nmea_frame_ram:
  - two DEPTH-byte banks;
  - byte write port on the inactive bank;
  - registered WORD_BYTES-wide read port with frame_len padding mask.
- The FSM, XOR accumulator and counters stay in the top level.

Test Plan:
- Send "$GPRMC,A*26":
  - frame_stb pulses once; frame_len=7; frame_valid=1;
  - rd_addr 0 → 0x4D525047;
  - rd_addr 1 → 0x20412C43.
- After the above, send "$GPRMC,B*26" (actual XOR 25):
  - err_stb pulses with err_code=01;
  - rd_addr 1 still → 0x20412C43; frame_len still 7.
- Send "$GPGGA,1*xx":
  - no frame_stb, no err_stb;
  - outputs unchanged.
- Send "$GP$GPRMC,A*26" (resync):
  - single frame_stb; same contents as scenario 1.
- DEPTH=64, send "$GPRMC" + 60 ',' bytes with no '*': err_code=10 on the 60th comma. Send "$GPRMC,\r": err_code=11.
- Assert reset mid-body, release, then poll: rd_data=0x20202020, frame_valid=0. Then a "$GPRMC,A*26" sentence is accepted normally.

Source files
------------

// File: rtl/nmea_pkg.sv
// Shared constants, state encoding and hex decoding for the NMEA sentence capture block.
package nmea_pkg;

    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_SPACE  = 8'h20;

    localparam int unsigned TAG_LEN = 5;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_CHECKSUM  = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b10;
    localparam logic [1:0] ERR_MALFORMED = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TAG,
        ST_BODY,
        ST_CK_HI,
        ST_CK_LO
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] nibble;
    } hex_t;

    // Decode one ASCII hex digit (0-9, A-F, a-f); valid=0 for anything else.
    function automatic hex_t hex_to_nibble(input logic [7:0] c);
        hex_t h;
        h.valid  = 1'b1;
        h.nibble = 4'h0;
        if (c >= 8'h30 && c <= 8'h39) begin
            h.nibble = 4'(c - 8'h30);
        end else if (c >= 8'h41 && c <= 8'h46) begin
            h.nibble = 4'(c - 8'h37);
        end else if (c >= 8'h61 && c <= 8'h66) begin
            h.nibble = 4'(c - 8'h57);
        end else begin
            h.valid = 1'b0;
        end
        return h;
    endfunction

endpackage

// File: rtl/nmea_frame_ram.sv
// Double-buffered sentence store: byte writes into the hidden bank, padded word reads
// from the displayed bank.
module nmea_frame_ram
    import nmea_pkg::*;
#(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                disp_bank,
    input  logic [$clog2(DEPTH):0]              frame_len,
    input  logic                                wr_en,
    input  logic [$clog2(DEPTH)-1:0]            wr_addr,
    input  logic [7:0]                          wr_data,
    input  logic [$clog2(DEPTH/WORD_BYTES)-1:0] rd_addr,
    output logic [8*WORD_BYTES-1:0]             rd_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [7:0]             bank0 [DEPTH];
    logic [7:0]             bank1 [DEPTH];
    logic [LW-1:0]          byte_idx;
    logic [8*WORD_BYTES-1:0] rd_word_c;

    // Writes always land in the bank that is not on display; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (disp_bank) begin
                bank0[wr_addr] <= wr_data;
            end else begin
                bank1[wr_addr] <= wr_data;
            end
        end
    end

    // Bytes past the end of the displayed sentence read back as spaces.
    always_comb begin
        rd_word_c = '0;
        byte_idx  = '0;
        for (int unsigned k = 0; k < WORD_BYTES; k++) begin
            byte_idx = LW'(rd_addr) * LW'(WORD_BYTES) + LW'(k);
            if (byte_idx < frame_len) begin
                rd_word_c[8*k +: 8] = disp_bank ? bank1[byte_idx[AW-1:0]]
                                                : bank0[byte_idx[AW-1:0]];
            end else begin
                rd_word_c[8*k +: 8] = ASCII_SPACE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_word_c;
        end
    end

endmodule

// File: rtl/nmea_sentence_capture.sv
// Captures one NMEA sentence type from a UART byte stream, verifies its checksum and
// publishes the last good sentence through a tear-free double buffer.
module nmea_sentence_capture
    import nmea_pkg::*;
#(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned WORD_BYTES = 4,
    parameter logic [39:0] TAG        = "GPRMC"
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [7:0]                          data,
    input  logic                                data_valid,
    input  logic [$clog2(DEPTH/WORD_BYTES)-1:0] rd_addr,
    output logic [8*WORD_BYTES-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]              frame_len,
    output logic                                frame_valid,
    output logic                                frame_stb,
    output logic                                err_stb,
    output logic [1:0]                          err_code
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    state_t        state, state_n;
    logic [LW-1:0] ptr, ptr_n;
    logic [7:0]    xor_acc, xor_n;
    logic [2:0]    tag_idx, tag_idx_n;
    logic [3:0]    ck_hi, ck_hi_n;
    logic          disp_bank, disp_bank_n;
    logic [LW-1:0] frame_len_n;
    logic          frame_valid_n;
    logic          frame_stb_n;
    logic          err_stb_n;
    logic [1:0]    err_code_n;

    logic [7:0]    tag_char_c;
    hex_t          hex_c;
    logic          ram_we_c;
    logic [AW-1:0] ram_waddr_c;
    logic [7:0]    ram_wdata_c;

    // Expected tag character for the current tag position, first char in the top byte.
    always_comb begin
        case (tag_idx)
            3'd0:    tag_char_c = TAG[39:32];
            3'd1:    tag_char_c = TAG[31:24];
            3'd2:    tag_char_c = TAG[23:16];
            3'd3:    tag_char_c = TAG[15:8];
            default: tag_char_c = TAG[7:0];
        endcase
    end

    always_comb begin
        state_n       = state;
        ptr_n         = ptr;
        xor_n         = xor_acc;
        tag_idx_n     = tag_idx;
        ck_hi_n       = ck_hi;
        disp_bank_n   = disp_bank;
        frame_len_n   = frame_len;
        frame_valid_n = frame_valid;
        frame_stb_n   = 1'b0;
        err_stb_n     = 1'b0;
        err_code_n    = err_code;
        ram_we_c      = 1'b0;
        ram_waddr_c   = ptr[AW-1:0];
        ram_wdata_c   = data;
        hex_c         = hex_to_nibble(data);

        if (data_valid) begin
            // A '$' anywhere starts a fresh sentence and silently drops a partial one.
            if (data == ASCII_DOLLAR) begin
                state_n   = ST_TAG;
                ptr_n     = '0;
                xor_n     = '0;
                tag_idx_n = '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state_n = ST_IDLE;
                    end
                    ST_TAG: begin
                        if (data == tag_char_c) begin
                            ram_we_c  = 1'b1;
                            ptr_n     = ptr + LW'(1);
                            xor_n     = xor_acc ^ data;
                            tag_idx_n = tag_idx + 3'd1;
                            if (tag_idx == 3'(TAG_LEN - 1)) begin
                                state_n = ST_BODY;
                            end
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end
                    ST_BODY: begin
                        if (data == ASCII_STAR) begin
                            state_n = ST_CK_HI;
                        end else if (data == ASCII_CR || data == ASCII_LF) begin
                            err_stb_n  = 1'b1;
                            err_code_n = ERR_MALFORMED;
                            state_n    = ST_IDLE;
                        end else if (ptr == LW'(DEPTH)) begin
                            err_stb_n  = 1'b1;
                            err_code_n = ERR_OVERFLOW;
                            state_n    = ST_IDLE;
                        end else begin
                            ram_we_c = 1'b1;
                            ptr_n    = ptr + LW'(1);
                            xor_n    = xor_acc ^ data;
                        end
                    end
                    ST_CK_HI: begin
                        if (hex_c.valid) begin
                            ck_hi_n = hex_c.nibble;
                            state_n = ST_CK_LO;
                        end else begin
                            err_stb_n  = 1'b1;
                            err_code_n = ERR_MALFORMED;
                            state_n    = ST_IDLE;
                        end
                    end
                    ST_CK_LO: begin
                        state_n = ST_IDLE;
                        if (!hex_c.valid) begin
                            err_stb_n  = 1'b1;
                            err_code_n = ERR_MALFORMED;
                        end else if ({ck_hi, hex_c.nibble} == xor_acc) begin
                            disp_bank_n   = ~disp_bank;
                            frame_len_n   = ptr;
                            frame_valid_n = 1'b1;
                            frame_stb_n   = 1'b1;
                        end else begin
                            err_stb_n  = 1'b1;
                            err_code_n = ERR_CHECKSUM;
                        end
                    end
                    default: begin
                        state_n = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            xor_acc     <= '0;
            tag_idx     <= '0;
            ck_hi       <= '0;
            disp_bank   <= 1'b0;
            frame_len   <= '0;
            frame_valid <= 1'b0;
            frame_stb   <= 1'b0;
            err_stb     <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            xor_acc     <= xor_n;
            tag_idx     <= tag_idx_n;
            ck_hi       <= ck_hi_n;
            disp_bank   <= disp_bank_n;
            frame_len   <= frame_len_n;
            frame_valid <= frame_valid_n;
            frame_stb   <= frame_stb_n;
            err_stb     <= err_stb_n;
            err_code    <= err_code_n;
        end
    end

    nmea_frame_ram #(
        .DEPTH      (DEPTH),
        .WORD_BYTES (WORD_BYTES)
    ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .disp_bank (disp_bank),
        .frame_len (frame_len),
        .wr_en     (ram_we_c),
        .wr_addr   (ram_waddr_c),
        .wr_data   (ram_wdata_c),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

endmodule

// File: tb/tb_nmea_sentence_capture.sv
// Directed and randomized sentences checked byte-by-byte against a queue-based sentence model.
module tb_nmea_sentence_capture;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned WB    = 4;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned RAW   = $clog2(DEPTH / WB);
    localparam logic [39:0] TAG   = "GPRMC";

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [7:0]      data = 8'h00;
    logic            data_valid = 1'b0;
    logic [RAW-1:0]  rd_addr = '0;
    logic [8*WB-1:0] rd_data;
    logic [AW:0]     frame_len;
    logic            frame_valid;
    logic            frame_stb;
    logic            err_stb;
    logic [1:0]      err_code;

    int tests = 0;
    int fails = 0;

    // Sentence model: bytes seen since the last '$', and the currently displayed sentence.
    bit         m_active = 1'b0;
    logic [7:0] m_q[$];
    int         m_star = -1;
    logic [7:0] m_disp[$];
    bit         m_valid = 1'b0;
    logic [1:0] m_code = 2'b00;

    always #5 clk = ~clk;

    nmea_sentence_capture #(
        .DEPTH      (DEPTH),
        .WORD_BYTES (WB),
        .TAG        (TAG)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data        (data),
        .data_valid  (data_valid),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_len   (frame_len),
        .frame_valid (frame_valid),
        .frame_stb   (frame_stb),
        .err_stb     (err_stb),
        .err_code    (err_code)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic logic [7:0] tag_chr(input int i);
        logic [39:0] t;
        t = TAG;
        return t[39-8*i -: 8];
    endfunction

    function automatic int hexval(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        return -1;
    endfunction

    function automatic logic [7:0] hex_chr(input logic [3:0] n, input bit lower);
        if (n < 4'd10) return 8'(8'h30 + n);
        return lower ? 8'(8'h57 + n) : 8'(8'h37 + n);
    endfunction

    function automatic logic [8*WB-1:0] exp_word(input int a);
        logic [8*WB-1:0] w;
        int idx;
        w = '0;
        for (int k = 0; k < int'(WB); k++) begin
            idx = a * int'(WB) + k;
            w[8*k +: 8] = (idx < m_disp.size()) ? m_disp[idx] : 8'h20;
        end
        return w;
    endfunction

    // Applies the sentence rules to one received byte; reports commit / reject events.
    task automatic model_byte(input logic [7:0] b, output logic ef, output logic ee);
        int n;
        int x;
        ef = 1'b0;
        ee = 1'b0;
        if (b == 8'h24) begin
            m_active = 1'b1;
            m_q.delete();
            m_star = -1;
            return;
        end
        if (!m_active) return;
        n = m_q.size();
        if (n < 5) begin
            if (b != tag_chr(n)) m_active = 1'b0;
            else m_q.push_back(b);
            return;
        end
        if (m_star < 0) begin
            if (b == 8'h2A) begin
                m_star = n;
                m_q.push_back(b);
            end else if (b == 8'h0D || b == 8'h0A) begin
                ee = 1'b1; m_code = 2'b11; m_active = 1'b0;
            end else if (n == int'(DEPTH)) begin
                ee = 1'b1; m_code = 2'b10; m_active = 1'b0;
            end else begin
                m_q.push_back(b);
            end
            return;
        end
        if (hexval(b) < 0) begin
            ee = 1'b1; m_code = 2'b11; m_active = 1'b0;
        end else if (n == m_star + 1) begin
            m_q.push_back(b);
        end else begin
            x = 0;
            for (int i = 0; i < m_star; i++) x = x ^ int'(m_q[i]);
            if (hexval(m_q[n-1]) * 16 + hexval(b) == x) begin
                m_disp.delete();
                for (int i = 0; i < m_star; i++) m_disp.push_back(m_q[i]);
                m_valid = 1'b1;
                ef = 1'b1;
            end else begin
                ee = 1'b1; m_code = 2'b01;
            end
            m_active = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ef, ee;
        @(negedge clk);
        data = b;
        data_valid = 1'b1;
        model_byte(b, ef, ee);
        @(negedge clk);
        data_valid = 1'b0;
        data = 8'h24;  // a '$' without data_valid must be ignored
        chk("frame_stb", 32'(frame_stb), 32'(ef));
        chk("err_stb", 32'(err_stb), 32'(ee));
        chk("err_code", 32'(err_code), 32'(m_code));
        chk("frame_len", 32'(frame_len), 32'(m_disp.size()));
        chk("frame_valid", 32'(frame_valid), 32'(m_valid));
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic check_read(input int a);
        @(negedge clk);
        rd_addr = RAW'(a);
        @(negedge clk);
        chk("rd_data", rd_data, exp_word(a));
    endtask

    task automatic send_random_sentence();
        logic [7:0] x;
        logic [7:0] c;
        int len;
        int mode;
        mode = $urandom_range(0, 9);
        x = 8'h00;
        repeat ($urandom_range(0, 2)) send_byte(8'($urandom_range(8'h25, 8'h7E)));
        send_byte(8'h24);
        for (int i = 0; i < 5; i++) begin
            c = tag_chr(i);
            if (mode == 0 && i == 3) c = 8'h58;
            send_byte(c);
            x = x ^ c;
        end
        len = $urandom_range(0, 62);
        for (int i = 0; i < len; i++) begin
            c = 8'($urandom_range(8'h20, 8'h7E));
            if (c == 8'h24 || c == 8'h2A) c = 8'h2E;
            if (mode == 1 && i == len / 2) c = 8'h0A;
            send_byte(c);
            x = x ^ c;
        end
        send_byte(8'h2A);
        if (mode == 2) x = x ^ 8'h01;
        send_byte(hex_chr(x[7:4], 1'($urandom_range(0, 1))));
        send_byte(mode == 3 ? 8'h47 : hex_chr(x[3:0], 1'($urandom_range(0, 1))));
        check_read($urandom_range(0, int'(DEPTH / WB) - 1));
        check_read($urandom_range(0, 2));
    endtask

    initial begin
        string ovf;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_frame_len", 32'(frame_len), 32'd0);
        chk("rst_frame_valid", 32'(frame_valid), 32'd0);
        chk("rst_frame_stb", 32'(frame_stb), 32'd0);
        chk("rst_err_stb", 32'(err_stb), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        reset = 1'b0;

        // Good sentence
        send_str("$GPRMC,A*26");
        chk("s1_len", 32'(frame_len), 32'd7);
        chk("s1_valid", 32'(frame_valid), 32'd1);
        check_read(0);
        chk("s1_word0", rd_data, 32'h4D525047);
        check_read(1);
        chk("s1_word1", rd_data, 32'h20412C43);

        // Checksum mismatch leaves the display untouched
        send_str("$GPRMC,B*26");
        chk("s2_code", 32'(err_code), 32'h1);
        check_read(1);
        chk("s2_word1", rd_data, 32'h20412C43);
        chk("s2_len", 32'(frame_len), 32'd7);

        // Other sentence type is ignored
        send_str("$GPGGA,1*xx");
        chk("s3_code", 32'(err_code), 32'h1);
        chk("s3_len", 32'(frame_len), 32'd7);

        // Resync on a second '$'
        send_str("$GP$GPRMC,A*26");
        check_read(0);
        chk("s4_word0", rd_data, 32'h4D525047);
        check_read(1);
        chk("s4_word1", rd_data, 32'h20412C43);

        // Overflow, then malformed
        ovf = "$GPRMC";
        for (int i = 0; i < 60; i++) ovf = {ovf, ","};
        send_str(ovf);
        chk("s5_ovf_code", 32'(err_code), 32'h2);
        send_str("$GPRMC,\r");
        chk("s5_malformed_code", 32'(err_code), 32'h3);

        // Reset in the middle of a body
        send_str("$GPRMC,AB");
        @(negedge clk);
        reset = 1'b1;
        m_active = 1'b0;
        m_disp.delete();
        m_valid = 1'b0;
        m_code = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        rd_addr = '0;
        @(negedge clk);
        chk("s6_pad", rd_data, 32'h20202020);
        chk("s6_valid", 32'(frame_valid), 32'd0);
        chk("s6_len", 32'(frame_len), 32'd0);
        check_read(3);
        send_str("$GPRMC,A*26");
        check_read(0);
        chk("s6_word0", rd_data, 32'h4D525047);
        check_read(1);

        // Randomized sentences
        for (int i = 0; i < 40; i++) send_random_sentence();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
